// File: rtl/mux2x1_arbiter_pkg.sv
// Shared constants for the packet-level two-input arbiter.
package mux2x1_arbiter_pkg;

  localparam logic [1:0] ST_ARB   = 2'd0;
  localparam logic [1:0] ST_LOCK0 = 2'd1;
  localparam logic [1:0] ST_LOCK1 = 2'd2;

  localparam logic SRC_IN0 = 1'b0;
  localparam logic SRC_IN1 = 1'b1;

  // Lock state that holds the given source until its last beat.
  function automatic logic [1:0] lock_state(input logic src);
    return (src == SRC_IN1) ? ST_LOCK1 : ST_LOCK0;
  endfunction

endpackage

// File: rtl/mux2x1_mux2x1.sv
// Plain 2:1 selector on the {last,data} beat payload.
module mux2x1
  import mux2x1_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 9
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sel,
  output logic [WIDTH-1:0] y_c
);

  assign y_c = (sel == SRC_IN1) ? in1 : in0;

endmodule

// File: rtl/mux2x1_arbiter.sv
// Round-robin, packet-locked arbiter merging two valid/ready streams into one
// registered output stream.
module mux2x1_arbiter
  import mux2x1_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_last,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  input  logic             in1_valid,
  output logic             in1_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_src,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned BEAT_W = WIDTH + 1;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              last_grant;
  logic              last_grant_nxt;
  logic              grant;
  logic              grant_vld;
  logic              load_en;
  logic              xfer;
  logic [BEAT_W-1:0] beat_c;

  assign load_en   = !out_valid || out_ready;
  assign xfer      = load_en && grant_vld;
  assign in0_ready = load_en && grant_vld && (grant == SRC_IN0) && in0_valid;
  assign in1_ready = load_en && grant_vld && (grant == SRC_IN1) && in1_valid;

  mux2x1 #(.WIDTH(BEAT_W)) u_mux (
    .in0 ({in0_last, in0_data}),
    .in1 ({in1_last, in1_data}),
    .sel (grant),
    .y_c (beat_c)
  );

  // Grant selection and packet-lock state transitions.
  always_comb begin
    grant          = SRC_IN0;
    grant_vld      = 1'b0;
    state_nxt      = state;
    last_grant_nxt = last_grant;
    case (state)
      ST_ARB: begin
        if (in0_valid && in1_valid) begin
          grant     = ~last_grant;
          grant_vld = 1'b1;
        end else if (in0_valid) begin
          grant     = SRC_IN0;
          grant_vld = 1'b1;
        end else if (in1_valid) begin
          grant     = SRC_IN1;
          grant_vld = 1'b1;
        end
        if (xfer) begin
          last_grant_nxt = grant;
          if (!beat_c[WIDTH]) state_nxt = lock_state(grant);
        end
      end
      ST_LOCK0: begin
        grant     = SRC_IN0;
        grant_vld = in0_valid;
        if (xfer && beat_c[WIDTH]) state_nxt = ST_ARB;
      end
      ST_LOCK1: begin
        grant     = SRC_IN1;
        grant_vld = in1_valid;
        if (xfer && beat_c[WIDTH]) state_nxt = ST_ARB;
      end
      default: state_nxt = ST_ARB;
    endcase
  end

  // last_grant resets to in1 so in0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_ARB;
      last_grant <= SRC_IN1;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= SRC_IN0;
    end else if (load_en) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= beat_c[WIDTH-1:0];
        out_last <= beat_c[WIDTH];
        out_src  <= grant;
      end
    end
  end

endmodule

// File: tb/tb_mux2x1_arbiter.sv
// Scoreboard bench for mux2x1_arbiter: source queues feed the inputs, expected
// beats are queued in arbitration order and popped as the consumer accepts them.
module tb_mux2x1_arbiter;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in0_data, in1_data;
  logic             in0_last, in1_last;
  logic             in0_valid, in1_valid;
  logic             in0_ready, in1_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last, out_src, out_valid;
  logic             out_ready;

  mux2x1_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_data(in0_data), .in0_last(in0_last), .in0_valid(in0_valid), .in0_ready(in0_ready),
    .in1_data(in1_data), .in1_last(in1_last), .in1_valid(in1_valid), .in1_ready(in1_ready),
    .out_data(out_data), .out_last(out_last), .out_src(out_src),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [9:0] exp_q[$];
  bit         en0 = 1'b1;
  bit         en1 = 1'b1;
  bit         h0 = 1'b0;
  bit         h1 = 1'b0;
  int         hs0 = 0;
  int         hs1 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_beat(input logic src, input logic last, input logic [7:0] data);
    if (src) q1.push_back({last, data});
    else     q0.push_back({last, data});
    exp_q.push_back({src, last, data});
  endtask

  task automatic wait_drain(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check(tag, 32'(done), 32'd1);
  endtask

  // Handshake sampling mid-cycle, away from the active edge.
  always @(negedge clk) begin
    h0 = rst_n && in0_valid && in0_ready;
    h1 = rst_n && in1_valid && in1_ready;
    if (h0) hs0++;
    if (h1) hs1++;
  end

  // Source drivers: retire accepted beats, present the next head beat.
  always @(posedge clk) begin
    #2;
    if (h0 && q0.size() > 0) void'(q0.pop_front());
    if (h1 && q1.size() > 0) void'(q1.pop_front());
    h0 = 1'b0;
    h1 = 1'b0;
    in0_valid = en0 && (q0.size() > 0);
    in1_valid = en1 && (q1.size() > 0);
    {in0_last, in0_data} = (q0.size() > 0) ? q0[0] : 9'h0;
    {in1_last, in1_data} = (q1.size() > 0) ? q1[0] : 9'h0;
  end

  // Output monitor: each accepted beat must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("beat", 32'({out_src, out_last, out_data}), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    bit seen;
    int base;
    rst_n = 1'b0;
    out_ready = 1'b1;
    in0_valid = 1'b0; in1_valid = 1'b0;
    in0_data = '0; in1_data = '0; in0_last = 1'b0; in1_last = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_last",  32'(out_last),  32'd0);
    check("rst_src",   32'(out_src),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-beat streams on both inputs: alternate starting with in0
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      push_beat(1'b0, 1'b1, 8'(8'h10 + i));
      if (i < 3) push_beat(1'b1, 1'b1, 8'(8'h20 + i));
    end
    @(negedge clk);
    check("lat_idle", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_first", 32'({out_valid, out_src, out_data}), 32'({1'b1, 1'b0, 8'h10}));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("thruput", 32'(out_valid), 32'd1);
    end
    wait_drain("drain_rr");

    // 3-beat packet on in1 locks out in0 (last grant was in0)
    for (int i = 0; i < 3; i++) push_beat(1'b1, 1'(i == 2), 8'(8'h30 + i));
    push_beat(1'b0, 1'b0, 8'h40);
    push_beat(1'b0, 1'b1, 8'h41);
    base = hs1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (hs1 >= base + 3) break;
      check("lock1_in0_ready", 32'(in0_ready), 32'd0);
    end
    wait_drain("drain_lock1");

    // Backpressure mid-packet on in0
    push_beat(1'b1, 1'b1, 8'h60);
    for (int i = 0; i < 3; i++) push_beat(1'b0, 1'(i == 2), 8'(8'h50 + i));
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk); #1;
      seen = out_valid;
    end
    check("bp_start", 32'(seen), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_hold", 32'({out_valid, out_src, out_data}), 32'({1'b1, 1'b0, 8'h50}));
      check("bp_ready", 32'({in0_ready, in1_ready}), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain("drain_bp");

    // Locked in0 bubbles for 2 cycles while in1 waits
    en1 = 1'b0;
    for (int i = 0; i < 3; i++) push_beat(1'b0, 1'(i == 2), 8'(8'h70 + i));
    push_beat(1'b1, 1'b1, 8'h80);
    base = hs0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      seen = (hs0 >= base + 1);
    end
    check("bub_start", 32'(seen), 32'd1);
    en0 = 1'b0;
    en1 = 1'b1;
    @(negedge clk);
    check("bub_in1_ready0", 32'(in1_ready), 32'd0);
    @(negedge clk);
    check("bub_in1_ready1", 32'(in1_ready), 32'd0);
    check("bub_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    en0 = 1'b1;
    wait_drain("drain_bub");

    // Reset during LOCK1 discards the packet; in0 wins afterwards
    out_ready = 1'b0;
    q1.push_back({1'b0, 8'hb0});
    q1.push_back({1'b0, 8'hb1});
    q1.push_back({1'b1, 8'hb2});
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk); #1;
      seen = out_valid;
    end
    check("lk1_start", 32'({seen, out_src, out_data}), 32'({1'b1, 1'b1, 8'hb0}));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 32'({out_valid, out_last, out_src, out_data}), 32'd0);
    q0.delete();
    q1.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    push_beat(1'b0, 1'b1, 8'h90);
    push_beat(1'b1, 1'b1, 8'ha0);
    wait_drain("drain_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
